// File: rtl/speed_pi_ctrl.sv
// speed_pi_ctrl: closed-loop speed regulator.
// Takes a pulses-per-window measurement and runs a PI update against a
// setpoint. The result is clamped to an 8-bit duty and drives a
// period-aligned PWM output. Everything is in the OUT_CLK domain.
//
// Handshake: Count_vld is a one-cycle strobe and has no ready. A strobe
// seen while Busy is high is remembered as a single pending update. That
// update carries the most recent Count and runs as soon as the FSM is back
// in IDLE. With Enable low every strobe is dropped.
module speed_pi_ctrl #(
    parameter int KP    = 4,
    parameter int KI    = 1,
    parameter int FRAC  = 4,
    parameter int I_MAX = 4095
) (
    input  logic       OUT_CLK,
    input  logic       RST,
    input  logic [7:0] Count,
    input  logic       Count_vld,
    input  logic [7:0] Setpoint,
    input  logic       Enable,
    output logic [7:0] Duty,
    output logic       PWM_OUT,
    output logic       Busy,
    output logic       Sat,
    output logic [2:0] state_dbg
);

    localparam int DW = 20;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ERR    = 3'd1;
    localparam logic [2:0] S_MAC    = 3'd2;
    localparam logic [2:0] S_CLAMP  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam logic signed [DW-1:0] KP_S  = DW'(KP);
    localparam logic signed [DW-1:0] KI_S  = DW'(KI);
    localparam logic signed [DW-1:0] I_HI  = DW'(I_MAX);
    localparam logic signed [DW-1:0] I_LO  = -I_HI;
    localparam logic signed [DW-1:0] S_MAX = 20'sd255;
    localparam logic [7:0]           PWM_LAST = 8'd254;

    logic [2:0]           state;
    logic [7:0]           cnt_lat;
    logic [7:0]           sp_lat;
    logic                 pend;
    logic [7:0]           pend_cnt;
    logic signed [8:0]    err_q;
    logic signed [DW-1:0] i_q;
    logic signed [DW-1:0] i_new_q;
    logic signed [DW-1:0] sum_q;
    logic [7:0]           clamp_q;
    logic                 clamp_sat_q;
    logic                 hold_q;

    logic [7:0]           pwm_cnt;
    logic [7:0]           shadow_duty;

    logic signed [8:0]    err_c;
    logic signed [DW-1:0] err_ext;
    logic signed [DW-1:0] p_c;
    logic signed [DW-1:0] i_acc;
    logic signed [DW-1:0] i_sat;
    logic signed [DW-1:0] sum_c;
    logic signed [DW-1:0] s_c;
    logic [7:0]           clamp_c;
    logic                 clamp_sat_c;
    logic                 hold_c;

    assign Busy      = (state != S_IDLE);
    assign state_dbg = state;

    // PI datapath: error, P and clamped I, then the shifted and clamped output.
    always_comb begin
        err_c   = $signed({1'b0, sp_lat}) - $signed({1'b0, cnt_lat});
        err_ext = {{(DW-9){err_q[8]}}, err_q};
        p_c     = KP_S * err_ext;
        i_acc   = i_q + KI_S * err_ext;
        i_sat   = i_acc;
        if (i_acc > I_HI) begin
            i_sat = I_HI;
        end else if (i_acc < I_LO) begin
            i_sat = I_LO;
        end
        sum_c = p_c + i_sat;

        // The arithmetic shift floors toward -inf, so -1000 >>> 4 gives -63.
        s_c         = sum_q >>> FRAC;
        clamp_c     = s_c[7:0];
        clamp_sat_c = 1'b0;
        if (s_c[DW-1]) begin
            clamp_c     = 8'd0;
            clamp_sat_c = 1'b1;
        end else if (s_c > S_MAX) begin
            clamp_c     = 8'd255;
            clamp_sat_c = 1'b1;
        end
        // Freeze the integrator when the output is saturated in the direction the error pushes.
        hold_c = ((s_c > S_MAX) && !err_q[8] && (err_q != 9'sd0)) ||
                 (s_c[DW-1] && err_q[8]);
    end

    // Control FSM, pending-strobe capture and integrator/duty update.
    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt_lat     <= 8'd0;
            sp_lat      <= 8'd0;
            pend        <= 1'b0;
            pend_cnt    <= 8'd0;
            err_q       <= 9'sd0;
            i_q         <= '0;
            i_new_q     <= '0;
            sum_q       <= '0;
            clamp_q     <= 8'd0;
            clamp_sat_q <= 1'b0;
            hold_q      <= 1'b0;
            Duty        <= 8'd0;
            Sat         <= 1'b0;
        end else if (!Enable) begin
            state <= S_IDLE;
            pend  <= 1'b0;
            i_q   <= '0;
            Duty  <= 8'd0;
            Sat   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Count_vld || pend) begin
                        cnt_lat <= Count_vld ? Count : pend_cnt;
                        sp_lat  <= Setpoint;
                        pend    <= 1'b0;
                        state   <= S_ERR;
                    end
                end
                S_ERR: begin
                    err_q <= err_c;
                    state <= S_MAC;
                end
                S_MAC: begin
                    i_new_q <= i_sat;
                    sum_q   <= sum_c;
                    state   <= S_CLAMP;
                end
                S_CLAMP: begin
                    clamp_q     <= clamp_c;
                    clamp_sat_q <= clamp_sat_c;
                    hold_q      <= hold_c;
                    state       <= S_UPDATE;
                end
                S_UPDATE: begin
                    Duty <= clamp_q;
                    Sat  <= clamp_sat_q;
                    if (!hold_q) begin
                        i_q <= i_new_q;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // A strobe during a busy cycle becomes the single pending update.
            if (Count_vld && (state != S_IDLE)) begin
                pend     <= 1'b1;
                pend_cnt <= Count;
            end
        end
    end

    // PWM: 255-cycle period. Shadow duty changes only at the period boundary.
    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            pwm_cnt     <= 8'd0;
            shadow_duty <= 8'd0;
            PWM_OUT     <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? 8'd0 : pwm_cnt + 8'd1;
            if (!Enable) begin
                shadow_duty <= 8'd0;
                PWM_OUT     <= 1'b0;
            end else begin
                if (pwm_cnt == PWM_LAST) begin
                    shadow_duty <= Duty;
                end
                PWM_OUT <= (pwm_cnt < shadow_duty);
            end
        end
    end

endmodule

// File: tb/tb_speed_pi_ctrl.sv
// tb_speed_pi_ctrl: table of PI update vectors, then hand-written
// sequences for PWM timing, pending strobes, reset and enable aborts.
module tb_speed_pi_ctrl;

    // ---------------- clock / reset ----------------
    logic       OUT_CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] Count = 8'd0;
    logic       Count_vld = 1'b0;
    logic [7:0] Setpoint = 8'd0;
    logic       Enable = 1'b0;
    logic [7:0] Duty;
    logic       PWM_OUT;
    logic       Busy;
    logic       Sat;
    logic [2:0] state_dbg;

    always #5 OUT_CLK = ~OUT_CLK;

    speed_pi_ctrl dut (
        .OUT_CLK   (OUT_CLK),
        .RST       (RST),
        .Count     (Count),
        .Count_vld (Count_vld),
        .Setpoint  (Setpoint),
        .Enable    (Enable),
        .Duty      (Duty),
        .PWM_OUT   (PWM_OUT),
        .Busy      (Busy),
        .Sat       (Sat),
        .state_dbg (state_dbg)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [28:0] exp_q[$];   // {duty[7:0], sat, integ[19:0]}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic s, input logic [19:0] i);
        exp_q.push_back({d, s, i});
    endtask

    task automatic pop_check(input string tag);
        logic [28:0] e;
        logic [19:0] act_i;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_sb: got 0 queued entries, expected 1", tag);
            return;
        end
        e     = exp_q.pop_front();
        act_i = dut.i_q;
        check({tag, "_duty"},  32'(Duty),  32'(e[28:21]));
        check({tag, "_sat"},   32'(Sat),   32'(e[20]));
        check({tag, "_integ"}, 32'(act_i), 32'(e[19:0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        RST       = 1'b1;
        Enable    = 1'b0;
        Count_vld = 1'b0;
        repeat (3) @(negedge OUT_CLK);
        RST = 1'b0;
        @(negedge OUT_CLK);
        check("rst_duty",  32'(Duty),      32'd0);
        check("rst_pwm",   32'(PWM_OUT),   32'd0);
        check("rst_busy",  32'(Busy),      32'd0);
        check("rst_sat",   32'(Sat),       32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        Enable = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic strobe(input logic [7:0] sp, input logic [7:0] cnt);
        Setpoint  = sp;
        Count     = cnt;
        Count_vld = 1'b1;
        @(negedge OUT_CLK);
        Count_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (Busy === 1'b1 && n < 20) begin
            n++;
            @(negedge OUT_CLK);
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'd4);
        pop_check(tag);
    endtask

    typedef struct {
        logic        rst_first;
        logic [7:0]  sp;
        logic [7:0]  cnt;
        logic [7:0]  exp_duty;
        logic        exp_sat;
        logic [19:0] exp_i;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int hi;
        int run;
        int nchg;
        int chg_k[2];
        logic [7:0]  prev;
        logic [19:0] act_i;

        // ---- vector table ----
        vecs[0] = '{1'b1, 8'd100, 8'd60,  8'd12, 1'b0, 20'd40};
        vecs[1] = '{1'b0, 8'd100, 8'd60,  8'd15, 1'b0, 20'd80};
        vecs[2] = '{1'b1, 8'd0,   8'd200, 8'd0,  1'b1, 20'd0};
        // Setpoint 255, Count 0: e=255, P=1020, I grows by 255 per window.
        for (int k = 1; k <= 14; k++) begin
            if (k <= 12)
                vecs[2+k] = '{(k == 1), 8'd255, 8'd0, 8'((1020 + 255*k) / 16), 1'b0, 20'(255*k)};
            else
                vecs[2+k] = '{1'b0, 8'd255, 8'd0, 8'd255, 1'b1, 20'd3060};
        end

        for (int v = 0; v < 17; v++) begin
            if (vecs[v].rst_first) do_reset();
            push_exp(vecs[v].exp_duty, vecs[v].exp_sat, vecs[v].exp_i);
            strobe(vecs[v].sp, vecs[v].cnt);
            wait_done($sformatf("vec%0d", v));
        end

        // ---- Duty=255 drives a constant high ----
        repeat (260) @(negedge OUT_CLK);
        hi = 0;
        repeat (255) begin
            if (PWM_OUT) hi++;
            @(negedge OUT_CLK);
        end
        check("pwm255_high", 32'(hi), 32'd255);

        // ---- Duty=0 from a negative sum stays low for a full period ----
        do_reset();
        push_exp(8'd0, 1'b1, 20'd0);
        strobe(8'd0, 8'd200);
        wait_done("negsat");
        hi = 0;
        repeat (300) begin
            if (PWM_OUT) hi++;
            @(negedge OUT_CLK);
        end
        check("pwm0_high", 32'(hi), 32'd0);

        // ---- Duty=12 loaded mid-period: no change until wrap, then 12/255 ----
        do_reset();
        push_exp(8'd12, 1'b0, 20'd40);
        strobe(8'd100, 8'd60);
        wait_done("pwm12");
        hi = 0;
        repeat (230) begin
            if (PWM_OUT) hi++;
            @(negedge OUT_CLK);
        end
        check("pwm12_early_high", 32'(hi), 32'd0);
        run = 0;
        while (!PWM_OUT && run < 60) begin
            run++;
            @(negedge OUT_CLK);
        end
        check("pwm12_rose", 32'(PWM_OUT), 32'd1);
        run = 0;
        while (PWM_OUT && run < 300) begin
            run++;
            @(negedge OUT_CLK);
        end
        check("pwm12_run", 32'(run), 32'd12);
        hi = run;
        repeat (255 - 12) begin
            if (PWM_OUT) hi++;
            @(negedge OUT_CLK);
        end
        check("pwm12_period_high", 32'(hi), 32'd12);

        // ---- two strobes two cycles apart: second uses Count=90 ----
        do_reset();
        push_exp(8'd12, 1'b0, 20'd40);
        push_exp(8'd5,  1'b0, 20'd50);
        strobe(8'd100, 8'd60);                 // k=0
        @(negedge OUT_CLK);                    // k=1
        Count     = 8'd90;
        Count_vld = 1'b1;
        @(negedge OUT_CLK);                    // k=2
        Count_vld = 1'b0;
        prev = 8'd0;
        nchg = 0;
        chg_k[0] = 0;
        chg_k[1] = 0;
        for (int k = 2; k <= 20; k++) begin
            if (Duty !== prev) begin
                if (nchg < 2) chg_k[nchg] = k;
                nchg++;
                pop_check($sformatf("pend_upd%0d", nchg));
                prev = Duty;
            end
            @(negedge OUT_CLK);
        end
        check("pend_nchg",  32'(nchg),         32'd2);
        check("pend_k1",    32'(chg_k[0]),     32'd4);
        check("pend_k2",    32'(chg_k[1]),     32'd9);
        check("pend_sb_left", 32'(exp_q.size()), 32'd0);

        // ---- RST during MAC aborts everything ----
        do_reset();
        push_exp(8'd12, 1'b0, 20'd40);
        strobe(8'd100, 8'd60);
        wait_done("pre_rst");
        strobe(8'd100, 8'd60);                 // ERR
        @(negedge OUT_CLK);                    // MAC
        check("mac_state", 32'(state_dbg), 32'd2);
        RST = 1'b1;
        #1;
        act_i = dut.i_q;
        check("midrst_duty",  32'(Duty),    32'd0);
        check("midrst_sat",   32'(Sat),     32'd0);
        check("midrst_busy",  32'(Busy),    32'd0);
        check("midrst_pwm",   32'(PWM_OUT), 32'd0);
        check("midrst_integ", 32'(act_i),   32'd0);
        @(negedge OUT_CLK);
        RST = 1'b0;
        @(negedge OUT_CLK);
        push_exp(8'd12, 1'b0, 20'd40);
        strobe(8'd100, 8'd60);
        wait_done("after_rst");

        // ---- Enable=0 during CLAMP, then Enable fall together with a strobe ----
        repeat (260) @(negedge OUT_CLK);       // Duty 12 now reaches PWM_OUT
        strobe(8'd100, 8'd60);                 // ERR
        @(negedge OUT_CLK);                    // MAC
        @(negedge OUT_CLK);                    // CLAMP
        check("clamp_state", 32'(state_dbg), 32'd3);
        Enable = 1'b0;
        @(negedge OUT_CLK);
        act_i = dut.i_q;
        check("dis_duty",  32'(Duty),      32'd0);
        check("dis_sat",   32'(Sat),       32'd0);
        check("dis_busy",  32'(Busy),      32'd0);
        check("dis_pwm",   32'(PWM_OUT),   32'd0);
        check("dis_integ", 32'(act_i),     32'd0);
        check("dis_state", 32'(state_dbg), 32'd0);
        Enable = 1'b1;
        @(negedge OUT_CLK);
        Enable    = 1'b0;
        Count     = 8'd60;
        Count_vld = 1'b1;
        @(negedge OUT_CLK);
        Enable    = 1'b1;
        Count_vld = 1'b0;
        @(negedge OUT_CLK);
        check("drop_busy1", 32'(Busy), 32'd0);
        @(negedge OUT_CLK);
        check("drop_busy2", 32'(Busy), 32'd0);
        push_exp(8'd12, 1'b0, 20'd40);
        strobe(8'd100, 8'd60);
        wait_done("after_dis");

        // ---- report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
